// File: rtl/idu_pkg.sv
// Shared decode types and RISC-V major opcode constants for the decode stage.
package idu_pkg;

  localparam logic [6:0] RV_OP     = 7'b0110011;
  localparam logic [6:0] RV_IMM    = 7'b0010011;
  localparam logic [6:0] RV_LD     = 7'b0000011;
  localparam logic [6:0] RV_ST     = 7'b0100011;
  localparam logic [6:0] RV_BR     = 7'b1100011;
  localparam logic [6:0] RV_JAL    = 7'b1101111;
  localparam logic [6:0] RV_JALR   = 7'b1100111;
  localparam logic [6:0] RV_LUI    = 7'b0110111;
  localparam logic [6:0] RV_AUIPC  = 7'b0010111;
  localparam logic [6:0] RV_SYS    = 7'b1110011;
  localparam logic [6:0] RV_OP_32  = 7'b0111011;
  localparam logic [6:0] RV_IMM_32 = 7'b0011011;

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmU,
    ImmS,
    ImmJ,
    ImmB
  } imm_fmt_e;

  // Instruction class, one-hot; all zero for unknown opcodes.
  typedef struct packed {
    logic i;
    logic u;
    logic s;
    logic j;
    logic r;
    logic b;
  } idu_cls_t;

  typedef struct packed {
    idu_cls_t   cls;
    logic       ld;
    logic       st;
    logic       br;
    logic       jal;
    logic       jalr;
    logic       j;
    logic       call;
    logic       ret;
    logic       w_inst;
    logic       mul;
    logic       div;
    logic       div_sign;
    logic       div_rem;
    logic       sys;
    logic [2:0] func3;
    logic       rd_we;
    logic       rs1_en;
    logic       rs2_en;
    logic       illegal;
  } idu_dec_t;

endpackage

// File: rtl/idu_dec.sv
// Combinational RISC-V instruction decoder: register fields, immediate and control bundle.
module idu_dec
  import idu_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter bit          HAS_M = 1'b1
) (
  input  logic [31:0]     inst_i,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [XLEN-1:0] imm_o,
  output idu_dec_t        dec_o
);

  localparam bit Rv32 = (XLEN == 32);

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  imm_fmt_e    fmt;
  logic        known;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic        is_op, is_op32, is_imm32, m_op, shift_imm, illegal;

  assign opcode = inst_i[6:0];
  assign func3  = inst_i[14:12];
  assign func7  = inst_i[31:25];
  assign rd_o   = inst_i[11:7];
  assign rs1_o  = inst_i[19:15];
  assign rs2_o  = inst_i[24:20];

  assign is_op    = (opcode == RV_OP);
  assign is_op32  = (opcode == RV_OP_32);
  assign is_imm32 = (opcode == RV_IMM_32);
  assign m_op     = (is_op | is_op32) & (func7 == 7'b0000001);
  // slli/srli/srai: shamt[5] is only meaningful on RV64
  assign shift_imm = (opcode == RV_IMM) & (func3[1:0] == 2'b01);

  // Opcode to immediate format; unknown opcodes are flagged.
  always_comb begin
    fmt   = ImmNone;
    known = 1'b1;
    case (opcode)
      RV_IMM, RV_IMM_32, RV_LD, RV_JALR, RV_SYS: fmt = ImmI;
      RV_LUI, RV_AUIPC:                          fmt = ImmU;
      RV_ST:                                     fmt = ImmS;
      RV_JAL:                                    fmt = ImmJ;
      RV_BR:                                     fmt = ImmB;
      RV_OP, RV_OP_32:                           fmt = ImmNone;
      default:                                   known = 1'b0;
    endcase
  end

  // Immediate assembly at 32 bits, then sign extension to XLEN.
  always_comb begin
    imm32 = '0;
    case (fmt)
      ImmI:    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      ImmU:    imm32 = {inst_i[31:12], 12'b0};
      ImmS:    imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      ImmJ:    imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      ImmB:    imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm64 = {{32{imm32[31]}}, imm32};
  assign imm_o = imm64[XLEN-1:0];

  assign illegal = (inst_i[1:0] != 2'b11) | ~known
                 | ((is_op32 | is_imm32) & Rv32)
                 | (m_op & ~HAS_M)
                 | (shift_imm & inst_i[25] & Rv32);

  // Control bundle; every action flag is suppressed for illegal instructions.
  always_comb begin
    dec_o         = '0;
    dec_o.func3   = func3;
    dec_o.illegal = illegal;
    dec_o.cls.i   = (fmt == ImmI);
    dec_o.cls.u   = (fmt == ImmU);
    dec_o.cls.s   = (fmt == ImmS);
    dec_o.cls.j   = (fmt == ImmJ);
    dec_o.cls.b   = (fmt == ImmB);
    dec_o.cls.r   = is_op | is_op32;
    if (!illegal) begin
      dec_o.ld       = (opcode == RV_LD);
      dec_o.st       = (opcode == RV_ST);
      dec_o.br       = (opcode == RV_BR);
      dec_o.jal      = (opcode == RV_JAL);
      dec_o.jalr     = (opcode == RV_JALR);
      dec_o.j        = dec_o.jal & (rd_o == 5'd0);
      dec_o.call     = (dec_o.jal | dec_o.jalr) & (rd_o == 5'd1);
      dec_o.ret      = dec_o.jalr & (rd_o == 5'd0) & (rs1_o == 5'd1) & (imm32 == 32'd0);
      dec_o.w_inst   = is_op32 | is_imm32;
      dec_o.mul      = m_op & ~func3[2];
      dec_o.div      = m_op & func3[2];
      dec_o.div_sign = dec_o.div & ~func3[0];
      dec_o.div_rem  = dec_o.div & func3[1];
      dec_o.sys      = (opcode == RV_SYS);
      dec_o.rd_we    = (rd_o != 5'd0) & ~(dec_o.cls.s | dec_o.cls.b);
      dec_o.rs1_en   = dec_o.cls.i | dec_o.cls.s | dec_o.cls.b | dec_o.cls.r;
      dec_o.rs2_en   = dec_o.cls.s | dec_o.cls.b | dec_o.cls.r;
    end
  end

endmodule

// File: rtl/idu_pipe.sv
// Decode stage register: decoder in front of a main entry plus a skid entry so that
// in_ready comes straight from a flop while still sustaining one instruction per cycle.
module idu_pipe
  import idu_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          HAS_M    = 1'b1,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output idu_dec_t        dec
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    idu_dec_t        dec;
  } entry_t;

  entry_t in_entry, reset_entry;
  entry_t main_d, main_q, skid_d, skid_q;
  logic   main_valid_d, main_valid_q, skid_valid_d, skid_valid_q;
  logic   accept, main_free;

  idu_dec #(
    .XLEN  (XLEN),
    .HAS_M (HAS_M)
  ) u_dec (
    .inst_i (in_inst),
    .rd_o   (in_entry.rd),
    .rs1_o  (in_entry.rs1),
    .rs2_o  (in_entry.rs2),
    .imm_o  (in_entry.imm),
    .dec_o  (in_entry.dec)
  );

  assign in_entry.pc   = in_pc;
  assign in_entry.inst = in_inst;

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  // Main can take new data when empty or when its current content leaves this cycle
  assign main_free = ~main_valid_q | out_ready;

  // Reset image of an entry: only the PC is non-zero.
  always_comb begin
    reset_entry    = '0;
    reset_entry.pc = RESET_PC[XLEN-1:0];
  end

  // Buffer next state: flush wins, then refill main (skid first for order), else spill to skid.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset overriding everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= reset_entry;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_pc    = main_q.pc;
  assign out_inst  = main_q.inst;
  assign rd        = main_q.rd;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign imm       = main_q.imm;
  assign dec       = main_q.dec;

endmodule

// File: tb/tb_idu_pipe.sv
// Scoreboard bench for idu_pipe: RV64+M instance for the pipeline and decode,
// RV32 without M instance for the width/extension legality rules.
module tb_idu_pipe;
  import idu_pkg::*;

  localparam logic [63:0] ResetPc = 64'h8000_0000;
  localparam logic [31:0] Addi    = 32'hfff10093;

  // Expected flag vector: {rd_we, illegal, ld, st, br, jal, jalr, j, ret, mul}
  localparam logic [9:0] FNone = 10'b0000000000;
  localparam logic [9:0] FWe   = 10'b1000000000;
  localparam logic [9:0] FIll  = 10'b0100000000;
  localparam logic [9:0] FLd   = 10'b0010000000;
  localparam logic [9:0] FSt   = 10'b0001000000;
  localparam logic [9:0] FBr   = 10'b0000100000;
  localparam logic [9:0] FJal  = 10'b0000010000;
  localparam logic [9:0] FJalr = 10'b0000001000;
  localparam logic [9:0] FJ    = 10'b0000000100;
  localparam logic [9:0] FRet  = 10'b0000000010;
  localparam logic [9:0] FMul  = 10'b0000000001;
  // Class one-hot {i,u,s,j,r,b}
  localparam logic [5:0] CNone = 6'b000000;
  localparam logic [5:0] CI    = 6'b100000;
  localparam logic [5:0] CU    = 6'b010000;
  localparam logic [5:0] CS    = 6'b001000;
  localparam logic [5:0] CJ    = 6'b000100;
  localparam logic [5:0] CR    = 6'b000010;
  localparam logic [5:0] CB    = 6'b000001;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [5:0]  cls;
    logic [9:0]  fl;
  } exp_t;

  typedef struct packed {
    logic        chk_imm;
    logic [31:0] imm;
    logic        ill;
    logic        we;
  } exp32_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc, imm;
  logic [31:0] in_inst, out_inst;
  logic [4:0]  rd, rs1, rs2;
  idu_dec_t    dec;

  logic        flush32, in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_pc32, out_pc32, imm32, in_inst32, out_inst32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  idu_dec_t    dec32;

  idu_pipe #(
    .XLEN     (64),
    .HAS_M    (1'b1),
    .RESET_PC (ResetPc)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .dec       (dec)
  );

  idu_pipe #(
    .XLEN     (32),
    .HAS_M    (1'b0),
    .RESET_PC (ResetPc)
  ) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_pc     (in_pc32),
    .in_inst   (in_inst32),
    .flush     (flush32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out_pc    (out_pc32),
    .out_inst  (out_inst32),
    .rd        (rd32),
    .rs1       (rs1_32),
    .rs2       (rs2_32),
    .imm       (imm32),
    .dec       (dec32)
  );

  int     checks = 0;
  int     errors = 0;
  exp_t   q[$];
  exp32_t q32[$];
  exp_t   mon_e;
  exp32_t mon_e32;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] erd, input logic [4:0] ers1,
                              input logic [4:0] ers2, input logic [63:0] eimm,
                              input logic [5:0] ecls, input logic [9:0] efl);
    exp_t e;
    e     = '0;
    e.rd  = erd;
    e.rs1 = ers1;
    e.rs2 = ers2;
    e.imm = eimm;
    e.cls = ecls;
    e.fl  = efl;
    return e;
  endfunction

  // Monitor for the RV64 instance: every output transfer is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %h expected no output", out_pc);
      end else begin
        mon_e = q.pop_front();
        check("out_pc", out_pc, mon_e.pc);
        check("payload", {out_inst, rd, rs1, rs2}, {mon_e.inst, mon_e.rd, mon_e.rs1, mon_e.rs2});
        check("imm", imm, mon_e.imm);
        check("dec", {dec.cls, dec.rd_we, dec.illegal, dec.ld, dec.st, dec.br, dec.jal,
                      dec.jalr, dec.j, dec.ret, dec.mul}, {mon_e.cls, mon_e.fl});
      end
    end
  end

  // Monitor for the RV32 instance.
  always @(negedge clk) begin
    if (!rst && out_valid32 && out_ready32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out32: got inst %h expected no output", out_inst32);
      end else begin
        mon_e32 = q32.pop_front();
        check("illegal32", dec32.illegal, mon_e32.ill);
        check("rd_we32", dec32.rd_we, mon_e32.we);
        if (mon_e32.chk_imm) check("imm32", imm32, mon_e32.imm);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic try_issue(input logic [63:0] pc, input logic [31:0] inst, input exp_t e,
                           output bit acc);
    exp_t ee;
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    acc      = in_ready;
    if (acc) begin
      ee      = e;
      ee.pc   = pc;
      ee.inst = inst;
      q.push_back(ee);
    end
    step();
  endtask

  task automatic issue(input logic [63:0] pc, input logic [31:0] inst, input exp_t e);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      try_issue(pc, inst, e, acc);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected accept of pc %h", pc);
    end else begin
      // An accepted instruction always leaves main valid on the following cycle
      check("out_valid_after_accept", out_valid, 1'b1);
    end
  endtask

  task automatic issue32(input logic [31:0] inst, input logic ill, input logic we,
                         input logic chk_imm, input logic [31:0] eimm);
    exp32_t e;
    e.chk_imm  = chk_imm;
    e.imm      = eimm;
    e.ill      = ill;
    e.we       = we;
    in_valid32 = 1'b1;
    in_inst32  = inst;
    in_pc32    = 32'h0;
    check("in_ready32", in_ready32, 1'b1);
    q32.push_back(e);
    step();
    in_valid32 = 1'b0;
  endtask

  initial begin
    bit acc;
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_pc       = '0;
    in_inst     = '0;
    out_ready   = 1'b1;
    flush32     = 1'b0;
    in_valid32  = 1'b0;
    in_pc32     = '0;
    in_inst32   = '0;
    out_ready32 = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_pc", out_pc, ResetPc);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_regs", {rd, rs1, rs2}, 15'h0);
    check("rst_imm", imm, 64'h0);
    check("rst_dec", 64'(dec), 64'h0);
    check("rst_out_pc32", out_pc32, ResetPc[31:0]);

    // addi x1,x2,-1 with one-cycle latency, then a back-to-back decode stream
    issue(64'h1000, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe));
    issue(64'h1004, 32'h00008067, mk(5'd0, 5'd1, 5'd0, 64'h0, CI, FJalr | FRet));
    issue(64'h1008, 32'h0080006f, mk(5'd0, 5'd0, 5'd8, 64'h8, CJ, FJal | FJ));
    issue(64'h100c, 32'h022081b3, mk(5'd3, 5'd1, 5'd2, 64'h0, CR, FWe | FMul));
    issue(64'h1010, 32'h01032283, mk(5'd5, 5'd6, 5'd16, 64'h10, CI, FWe | FLd));
    issue(64'h1014, 32'hFE742E23, mk(5'd28, 5'd8, 5'd7, 64'hFFFF_FFFF_FFFF_FFFC, CS, FSt));
    issue(64'h1018, 32'hFE208CE3, mk(5'd25, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFF8, CB, FBr));
    issue(64'h101c, 32'h80000537, mk(5'd10, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000, CU, FWe));
    issue(64'h1020, 32'h00000000, mk(5'd0, 5'd0, 5'd0, 64'h0, CNone, FIll));
    issue(64'h1024, 32'h00000013, mk(5'd0, 5'd0, 5'd0, 64'h0, CI, FNone));
    step();
    step();
    check("drained_out_valid", out_valid, 1'b0);

    // Stall: main and skid fill, third is held off, then release drains in order
    out_ready = 1'b0;
    issue(64'h100, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe));
    issue(64'h104, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe));
    check("stall_in_ready", in_ready, 1'b0);
    try_issue(64'h108, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe), acc);
    check("stall_hold_pc", out_pc, 64'h100);
    check("stall_in_ready_held", in_ready, 1'b0);
    out_ready = 1'b1;
    issue(64'h108, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe));
    repeat (3) step();
    check("stall_drained", out_valid, 1'b0);

    // Flush with both entries held and an input offered
    out_ready = 1'b0;
    issue(64'h200, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe));
    issue(64'h204, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe));
    in_valid = 1'b1;
    in_pc    = 64'h208;
    in_inst  = Addi;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush2_out_valid", out_valid, 1'b0);
    check("flush2_in_ready", in_ready, 1'b1);
    q.delete();

    // Flush with only main held: the offered input sees in_ready=1 but must be dropped
    issue(64'h300, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe));
    in_valid = 1'b1;
    in_pc    = 64'h304;
    in_inst  = Addi;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush1_out_valid", out_valid, 1'b0);
    q.delete();
    out_ready = 1'b1;
    repeat (3) step();
    check("flush1_dropped", out_valid, 1'b0);

    // Reset while stalled with both entries held
    out_ready = 1'b0;
    issue(64'h400, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe));
    issue(64'h404, Addi, mk(5'd1, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, CI, FWe));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_pc", out_pc, ResetPc);
    check("midrst_in_ready", in_ready, 1'b1);
    q.delete();
    out_ready = 1'b1;
    repeat (3) step();
    check("midrst_no_out", out_valid, 1'b0);

    // RV32 without M: width and extension legality
    issue32(32'h0010009b, 1'b1, 1'b0, 1'b0, 32'h0);
    issue32(32'h022081b3, 1'b1, 1'b0, 1'b0, 32'h0);
    issue32(32'h02009093, 1'b1, 1'b0, 1'b0, 32'h0);
    issue32(32'h01f09093, 1'b0, 1'b1, 1'b1, 32'h1f);
    issue32(Addi, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (3) step();

    check("sb_empty", 64'(q.size()), 64'h0);
    check("sb32_empty", 64'(q32.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu_pipe.md
IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath/immediate width; legal values are 32 or 64.
REQ-002 SHALL have parameter HAS_M, default 1, meaning M-extension decode is enabled; when 0, M ops are illegal.
REQ-003 SHALL have parameter RESET_PC, default 64'h8000_0000, meaning the out_pc value after reset; it is truncated to XLEN.
REQ-004 SHALL have port clk  in  1  meaning single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  meaning reset: synchronous, active-high.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1, in_pc in XLEN, in_inst in 32: the fetch-side handshake.
REQ-007 SHALL have port flush  in  1  meaning kill all held instructions.
REQ-008 SHALL have ports out_valid out 1, out_ready in 1, out_pc out XLEN, out_inst out 32: the execute-side handshake.
REQ-009 SHALL have ports rd/rs1/rs2 out 5 each, imm out XLEN, and dec out idu_dec_t (decoded control bundle).

Function
REQ-010 SHALL transfer on the input side when in_valid&in_ready and on the output side when out_valid&out_ready; latency from accept to out_valid SHALL be 1 cycle when the output is not stalled.
REQ-011 SHALL hold two decoded entries: main (drives outputs) and skid; in_ready SHALL equal ~skid_valid, taken directly from a register.
REQ-012 When main is empty or drains this cycle, main SHALL load from skid if skid is valid, else from the accepted input; skid then clears.
REQ-013 When main is valid and stalled (out_ready=0) and an input is accepted, skid SHALL capture it; program order SHALL be preserved.
REQ-014 Decode SHALL be computed before the register stage; out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-015 Immediate SHALL be I/U/S/J/B-format sign-extended from inst[31] to XLEN; R-format and unknown opcodes SHALL give 0.
REQ-016 dec SHALL contain: class one-hot {I,U,S,J,R,B}, flags ld, st, br, jal, jalr, j (jal with rd=0), call, ret (jalr, rd=0, rs1=1, imm=0), w_inst, mul, div, div_sign, div_rem, sys, and fields func3, rd_we, rs1_en, rs2_en, illegal.
REQ-017 illegal SHALL be set for any of: inst[1:0]!=2'b11; an unknown opcode; OP_32/IMM_32 when XLEN=32; an M op when HAS_M=0; slli/srli/srai with inst[25]=1 when XLEN=32.
REQ-018 When illegal is set, rd_we SHALL be 0 and all other action flags SHALL be 0.
REQ-019 rd_we SHALL be 0 whenever rd=0.
REQ-020 flush SHALL clear main_valid and skid_valid next cycle, and an input presented in the flush cycle SHALL be dropped; flush SHALL have priority over every other event.
REQ-021 Simultaneous drain of main and accept of input with skid empty SHALL load main directly; no bubble is permitted.

Reset
REQ-022 On rst, main_valid, skid_valid and out_valid SHALL be 0, and in_ready SHALL be 1 in the cycle after reset.
REQ-023 On rst, out_pc SHALL be RESET_PC, and out_inst, rd, rs1, rs2, imm and dec SHALL be 0.
REQ-024 rst SHALL override flush and handshakes; rst asserted mid-stall SHALL discard both entries.

Structure
REQ-025 Package idu_pkg SHALL hold the opcode constants (RV_OP, RV_IMM, RV_LD, RV_ST, RV_BR, RV_JAL, RV_JALR, RV_LUI, RV_AUIPC, RV_SYS, RV_OP_32, RV_IMM_32), idu_dec_t and the imm-format enum.
REQ-026 Combinational decode SHALL be one sub-module, idu_dec (parameters XLEN, HAS_M); idu_pipe SHALL contain only the buffer, handshake and flush logic.

Verification
REQ-027 XLEN=64, in_inst=0xfff10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFF_FFFF_FFFF_FFFF, class I, rd_we=1.
REQ-028 out_ready=0, in_valid=1 for 3 cycles with PCs 0x100/0x104/0x108 -> in_ready=0 after the 2nd accept; releasing out_ready yields 0x100 then 0x104 then 0x108 on consecutive cycles.
REQ-029 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flush-cycle instruction is never output.
REQ-030 XLEN=32, in_inst=0x0010009b (addiw) -> illegal=1, rd_we=0; XLEN=32, HAS_M=0, mul 0x022081b3 -> illegal=1.
REQ-031 in_inst=0x00008067 (ret) -> jalr=1, ret=1, rd_we=0; 0x0080006f (jal x0,8) -> j=1, imm=8.
REQ-032 rst asserted with both entries held -> next cycle out_valid=0, out_pc=RESET_PC, in_ready=1.
